bp_update_ctrl: RTL and testbench

- Sequences all writes into the global-history branch predictor table.
- Accepts resolved branches from EX into a small FIFO and issues them one at a time to the predictor's update port over a valid/ready handshake.
- Owns the speculative global history register (GHR) used at fetch, including repair on mispredict.
- Walks the table through initialisation after reset or on software request, so the table itself needs no reset loop.

---
 rtl/bp_update_ctrl_pkg.sv | 26 ++
 rtl/bp_update_ctrl_if.sv | 34 +++
 rtl/bp_update_ctrl_fifo.sv | 60 ++++++
 rtl/bp_update_ctrl.sv | 144 ++++++++++++++
 tb/tb_bp_update_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_update_ctrl_pkg.sv
// Shared types for the branch-predictor update controller: controller states,
// the queued update payload and a history shift helper.
package bp_update_ctrl_pkg;

  localparam int unsigned BP_PC_W  = 32;
  localparam int unsigned BP_GHR_W = 5;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } bp_ctrl_state_t;

  typedef struct packed {
    logic [BP_PC_W-1:0]  pc;
    logic                taken;
    logic [BP_GHR_W-1:0] ghr;
  } bp_upd_t;

  // Shift one outcome into the youngest end of a history vector.
  function automatic logic [BP_GHR_W-1:0] ghr_shift(input logic [BP_GHR_W-1:0] hist,
                                                    input logic                taken);
    return {hist[BP_GHR_W-2:0], taken};
  endfunction

endpackage

// File: rtl/bp_update_ctrl_if.sv
// Resolve-side and table-update-side handshakes of the predictor update controller.
interface bp_update_ctrl_if
  import bp_update_ctrl_pkg::*;
#(
  parameter int unsigned S_GBHR = BP_GHR_W
);

  logic                res_valid;
  logic                res_ready;
  logic [BP_PC_W-1:0]  res_pc;
  logic                res_taken;
  logic                res_mispredict;
  logic [S_GBHR-1:0]   res_ghr;

  logic                upd_valid;
  logic                upd_ready;
  logic                upd_init;
  logic [BP_PC_W-1:0]  upd_pc;
  logic                upd_taken;
  logic [S_GBHR-1:0]   upd_ghr;

  // Controller side
  modport master (
    input  res_valid, res_pc, res_taken, res_mispredict, res_ghr, upd_ready,
    output res_ready, upd_valid, upd_init, upd_pc, upd_taken, upd_ghr
  );

  // EX / predictor-table side
  modport slave (
    output res_valid, res_pc, res_taken, res_mispredict, res_ghr, upd_ready,
    input  res_ready, upd_valid, upd_init, upd_pc, upd_taken, upd_ghr
  );

endinterface

// File: rtl/bp_update_ctrl_fifo.sv
// DEPTH-entry FIFO of resolved branches; exposes next-cycle head/flags so the
// owner can register its output stage straight from the FIFO.
module bp_update_ctrl_fifo
  import bp_update_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  bp_upd_t                  wdata_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_c_o,
  output logic                     empty_nxt_c_o,
  output logic                     full_nxt_c_o,
  output bp_upd_t                  head_nxt_c_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  bp_upd_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               push_ok, pop_ok;

  assign push_ok = push_i & (cnt_q != CNT_W'(DEPTH));
  assign pop_ok  = pop_i  & (cnt_q != '0);

  always_comb begin
    wr_d  = wr_q + PTR_W'(push_ok);
    rd_d  = rd_q + PTR_W'(pop_ok);
    cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // The slot about to become head may be the one written this cycle.
  assign head_nxt_c_o  = (push_ok && (wr_q == rd_d)) ? wdata_i : mem_q[rd_d];
  assign empty_c_o     = (cnt_q == '0);
  assign empty_nxt_c_o = (cnt_d == '0);
  assign full_nxt_c_o  = (cnt_d == CNT_W'(DEPTH));
  assign count_o       = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// Sequences every write into the global-history predictor table: init walk,
// resolved-branch updates through a FIFO, speculative GHR and its repair.
module bp_update_ctrl
  import bp_update_ctrl_pkg::*;
#(
  parameter int unsigned S_PC_IDX    = 12,
  parameter int unsigned S_PC_OFFSET = 2,
  parameter int unsigned S_GBHR      = BP_GHR_W,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reinit_req,
  output logic                    busy,
  bp_update_ctrl_if.master        bus,
  input  logic                    pred_valid,
  input  logic                    pred_taken,
  output logic [S_GBHR-1:0]       spec_ghr,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [31:0]             mispred_cnt
);

  bp_ctrl_state_t        state_q, state_d;
  logic [S_PC_IDX-1:0]   init_idx_q, init_idx_d;
  logic [S_GBHR-1:0]     spec_ghr_q, spec_ghr_d;
  logic [31:0]           mispred_q, mispred_d;
  logic                  busy_q, busy_d;
  logic                  res_ready_q, res_ready_d;
  logic                  upd_valid_q, upd_valid_d;
  logic                  upd_init_q, upd_init_d;
  bp_upd_t               upd_q, upd_d;

  bp_upd_t               res_pkt, head_nxt;
  logic                  fire, push, pop, res_mis;
  logic                  empty_c, empty_nxt, full_nxt;

  assign res_pkt.pc    = bus.res_pc;
  assign res_pkt.taken = bus.res_taken;
  assign res_pkt.ghr   = BP_GHR_W'(bus.res_ghr);

  assign fire    = upd_valid_q & bus.upd_ready;
  assign push    = bus.res_valid & res_ready_q;
  assign pop     = fire & (state_q != INIT);
  assign res_mis = push & bus.res_mispredict;

  bp_update_ctrl_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .rst_n         (rst),
    .push_i        (push),
    .wdata_i       (res_pkt),
    .pop_i         (pop),
    .count_o       (occupancy),
    .empty_c_o     (empty_c),
    .empty_nxt_c_o (empty_nxt),
    .full_nxt_c_o  (full_nxt),
    .head_nxt_c_o  (head_nxt)
  );

  // Next state, history, and the registered update-port image.
  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    spec_ghr_d  = spec_ghr_q;
    mispred_d   = mispred_q;
    upd_valid_d = 1'b0;
    upd_init_d  = 1'b0;
    upd_d       = head_nxt;

    case (state_q)
      INIT: begin
        if (fire) begin
          init_idx_d = init_idx_q + S_PC_IDX'(1);
          if (init_idx_q == '1) state_d = RUN;
        end
      end
      RUN:     if (reinit_req) state_d = DRAIN;
      DRAIN:   if (empty_c) state_d = INIT;
      default: state_d = INIT;
    endcase

    // A mispredict repair squashes any same-cycle younger prediction.
    if (state_q == RUN) begin
      if (res_mis) begin
        spec_ghr_d = S_GBHR'(ghr_shift(BP_GHR_W'(bus.res_ghr), bus.res_taken));
        if (mispred_q != '1) mispred_d = mispred_q + 32'd1;
      end else if (pred_valid) begin
        spec_ghr_d = S_GBHR'(ghr_shift(BP_GHR_W'(spec_ghr_q), pred_taken));
      end
    end

    if ((state_d == INIT) && (state_q != INIT)) begin
      spec_ghr_d = '0;
      mispred_d  = '0;
    end

    if (state_d == INIT) begin
      upd_valid_d = 1'b1;
      upd_init_d  = 1'b1;
      upd_d.pc    = BP_PC_W'(init_idx_d) << S_PC_OFFSET;
      upd_d.taken = 1'b0;
      upd_d.ghr   = '0;
    end else begin
      upd_valid_d = ~empty_nxt;
    end

    busy_d      = (state_d != RUN);
    res_ready_d = (state_d == RUN) & ~full_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INIT;
      init_idx_q  <= '0;
      spec_ghr_q  <= '0;
      mispred_q   <= '0;
      busy_q      <= 1'b1;
      res_ready_q <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_init_q  <= 1'b0;
      upd_q       <= '0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      spec_ghr_q  <= spec_ghr_d;
      mispred_q   <= mispred_d;
      busy_q      <= busy_d;
      res_ready_q <= res_ready_d;
      upd_valid_q <= upd_valid_d;
      upd_init_q  <= upd_init_d;
      upd_q       <= upd_d;
    end
  end

  assign busy          = busy_q;
  assign spec_ghr      = spec_ghr_q;
  assign mispred_cnt   = mispred_q;
  assign bus.res_ready = res_ready_q;
  assign bus.upd_valid = upd_valid_q;
  assign bus.upd_init  = upd_init_q;
  assign bus.upd_pc    = upd_q.pc;
  assign bus.upd_taken = upd_q.taken;
  assign bus.upd_ghr   = S_GBHR'(upd_q.ghr);

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl: init walk, FIFO backpressure/order,
// GHR repair priority, reinit drain and asynchronous reset mid-operation.
module tb_bp_update_ctrl;
  import bp_update_ctrl_pkg::*;

  localparam int unsigned GW   = 5;
  localparam int unsigned ROWS = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reinit_req;
  logic        busy;
  logic        pred_valid;
  logic        pred_taken;
  logic [GW-1:0] spec_ghr;
  logic [2:0]  occupancy;
  logic [31:0] mispred_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bp_update_ctrl_if #(.S_GBHR(GW)) bus ();

  bp_update_ctrl #(
    .S_PC_IDX(12), .S_PC_OFFSET(2), .S_GBHR(GW), .DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .reinit_req (reinit_req),
    .busy       (busy),
    .bus        (bus),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .spec_ghr   (spec_ghr),
    .occupancy  (occupancy),
    .mispred_cnt(mispred_cnt)
  );

  logic [31:0]   v_pc  [5] = '{32'h0000_1000, 32'h0000_2004, 32'h0000_3008, 32'h0000_400C, 32'h0000_5010};
  logic          v_tk  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [GW-1:0] v_ghr [5] = '{5'h03, 5'h1F, 5'h00, 5'h15, 5'h0A};
  logic          p_bits[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_res();
    bus.res_valid      = 1'b0;
    bus.res_pc         = '0;
    bus.res_taken      = 1'b0;
    bus.res_mispredict = 1'b0;
    bus.res_ghr        = '0;
  endtask

  task automatic drive_res(input logic [31:0] pc, input logic tk, input logic mis,
                           input logic [GW-1:0] g);
    bus.res_valid      = 1'b1;
    bus.res_pc         = pc;
    bus.res_taken      = tk;
    bus.res_mispredict = mis;
    bus.res_ghr        = g;
  endtask

  // Starting at a sample point showing the first init write, walk the whole table.
  task automatic run_init(input string tag);
    int n, good, bad;
    n = 0; good = 0; bad = 0;
    bus.upd_ready = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      if (n == int'(ROWS)) break;
      if (!busy || bus.res_ready) bad++;
      if (bus.upd_valid) begin
        if (bus.upd_init && bus.upd_pc == (32'(n) << 2) && !bus.upd_taken && bus.upd_ghr == '0)
          good++;
        n++;
      end
      tick();
    end
    chk({tag, "_writes"}, 64'(n), 64'(ROWS));
    chk({tag, "_pc_seq"}, 64'(good), 64'(ROWS));
    chk({tag, "_busy_rdy_during"}, 64'(bad), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_res_ready_after"}, 64'(bus.res_ready), 64'd1);
    chk({tag, "_upd_valid_after"}, 64'(bus.upd_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] dpc [3];
    int nd, bad, seen, found;

    reinit_req = 1'b0; pred_valid = 1'b0; pred_taken = 1'b0;
    bus.upd_ready = 1'b0;
    idle_res();

    // Reset values
    #2 rst = 1'b0;
    #2;
    chk("rst_upd_valid", 64'(bus.upd_valid), 64'd0);
    chk("rst_res_ready", 64'(bus.res_ready), 64'd0);
    chk("rst_busy",      64'(busy),          64'd1);
    chk("rst_occupancy", 64'(occupancy),     64'd0);
    chk("rst_spec_ghr",  64'(spec_ghr),      64'd0);
    chk("rst_mispred",   64'(mispred_cnt),   64'd0);

    @(negedge clk) rst = 1'b1;
    tick();
    run_init("init1");

    // Backpressure: five offers, four accepted
    bus.upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_res(v_pc[i], v_tk[i], 1'b0, v_ghr[i]);
      chk($sformatf("bp_res_ready_%0d", i), 64'(bus.res_ready), (i < 4) ? 64'd1 : 64'd0);
      tick();
    end
    idle_res();
    chk("bp_occupancy", 64'(occupancy), 64'd4);
    chk("bp_res_ready_full", 64'(bus.res_ready), 64'd0);
    chk("bp_upd_valid", 64'(bus.upd_valid), 64'd1);
    tick(); tick();
    chk("bp_stable_pc", 64'(bus.upd_pc), 64'(v_pc[0]));
    chk("bp_stable_valid", 64'(bus.upd_valid), 64'd1);
    chk("bp_init_flag", 64'(bus.upd_init), 64'd0);
    bus.upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_pc_%0d", i),  64'(bus.upd_pc),    64'(v_pc[i]));
      chk($sformatf("drain_tk_%0d", i),  64'(bus.upd_taken), 64'(v_tk[i]));
      chk($sformatf("drain_ghr_%0d", i), 64'(bus.upd_ghr),   64'(v_ghr[i]));
      tick();
    end
    chk("drain_done_valid", 64'(bus.upd_valid), 64'd0);
    chk("drain_done_occ", 64'(occupancy), 64'd0);

    // Push and pop in the same cycle
    drive_res(32'h0000_5000, 1'b1, 1'b0, 5'h01);
    tick();
    chk("pp_occ1", 64'(occupancy), 64'd1);
    chk("pp_pc_a", 64'(bus.upd_pc), 64'h5000);
    drive_res(32'h0000_6000, 1'b0, 1'b0, 5'h02);
    tick();
    idle_res();
    chk("pp_occ_same", 64'(occupancy), 64'd1);
    chk("pp_pc_b", 64'(bus.upd_pc), 64'h6000);
    tick();
    chk("pp_empty_valid", 64'(bus.upd_valid), 64'd0);
    chk("pp_empty_occ", 64'(occupancy), 64'd0);

    // Build history 10110, then repair wins over a same-cycle prediction
    chk("ghr_start", 64'(spec_ghr), 64'd0);
    for (int i = 0; i < 5; i++) begin
      pred_valid = 1'b1; pred_taken = p_bits[i];
      tick();
    end
    chk("ghr_built", 64'(spec_ghr), 64'b10110);
    pred_valid = 1'b1; pred_taken = 1'b1;
    drive_res(32'h0000_7000, 1'b0, 1'b1, 5'b00011);
    tick();
    pred_valid = 1'b0; idle_res();
    chk("ghr_repair", 64'(spec_ghr), 64'b00110);
    chk("mispred_1", 64'(mispred_cnt), 64'd1);
    chk("repair_upd_ghr", 64'(bus.upd_ghr), 64'b00011);
    chk("repair_upd_taken", 64'(bus.upd_taken), 64'd0);
    tick();

    // Reinit with three queued entries
    bus.upd_ready = 1'b0;
    drive_res(32'h0000_8000, 1'b0, 1'b0, 5'h04); tick();
    drive_res(32'h0000_8004, 1'b1, 1'b1, 5'h1F); tick();
    drive_res(32'h0000_8008, 1'b0, 1'b0, 5'h05); tick();
    idle_res();
    chk("ri_occ3", 64'(occupancy), 64'd3);
    chk("ri_mispred2", 64'(mispred_cnt), 64'd2);
    chk("ri_ghr", 64'(spec_ghr), 64'b11111);
    reinit_req = 1'b1;
    tick();
    reinit_req = 1'b0;
    chk("ri_busy", 64'(busy), 64'd1);
    drive_res(32'hDEAD_0000, 1'b1, 1'b1, 5'h1F);
    nd = 0; bad = 0; seen = 0;
    for (int c = 0; c < 60; c++) begin
      if (bus.upd_valid && bus.upd_init) begin seen = 1; break; end
      if (bus.res_ready) bad++;
      bus.upd_ready = c[0];
      if (bus.upd_valid && bus.upd_ready) begin
        if (nd < 3) dpc[nd] = bus.upd_pc;
        nd++;
      end
      tick();
    end
    idle_res();
    chk("ri_seen_init", 64'(seen), 64'd1);
    chk("ri_drained", 64'(nd), 64'd3);
    chk("ri_pc0", 64'(dpc[0]), 64'h8000);
    chk("ri_pc1", 64'(dpc[1]), 64'h8004);
    chk("ri_pc2", 64'(dpc[2]), 64'h8008);
    chk("ri_res_ready_low", 64'(bad), 64'd0);
    chk("ri_init_pc0", 64'(bus.upd_pc), 64'd0);
    chk("ri_ghr_clr", 64'(spec_ghr), 64'd0);
    chk("ri_mispred_clr", 64'(mispred_cnt), 64'd0);
    chk("ri_occ0", 64'(occupancy), 64'd0);

    // Asynchronous reset in the middle of INIT at idx 100
    bus.upd_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 300; c++) begin
      if (bus.upd_valid && bus.upd_pc == 32'd400) begin found = 1; break; end
      tick();
    end
    chk("ar_reach_idx100", 64'(found), 64'd1);
    rst = 1'b0;
    #1;
    chk("ar_init_valid", 64'(bus.upd_valid), 64'd0);
    chk("ar_init_busy", 64'(busy), 64'd1);
    chk("ar_init_pc", 64'(bus.upd_pc), 64'd0);
    @(negedge clk) rst = 1'b1;
    tick();
    chk("ar_restart_valid", 64'(bus.upd_valid), 64'd1);
    chk("ar_restart_pc", 64'(bus.upd_pc), 64'd0);
    run_init("init2");

    // Asynchronous reset in RUN with two entries queued
    bus.upd_ready = 1'b0;
    pred_valid = 1'b1; pred_taken = 1'b1;
    drive_res(32'h0000_9000, 1'b1, 1'b0, 5'h06); tick();
    pred_valid = 1'b0;
    drive_res(32'h0000_9004, 1'b0, 1'b0, 5'h07); tick();
    idle_res();
    chk("ar_run_occ2", 64'(occupancy), 64'd2);
    chk("ar_run_ghr", 64'(spec_ghr), 64'b00001);
    rst = 1'b0;
    #1;
    chk("ar_run_occ0", 64'(occupancy), 64'd0);
    chk("ar_run_valid", 64'(bus.upd_valid), 64'd0);
    chk("ar_run_res_ready", 64'(bus.res_ready), 64'd0);
    chk("ar_run_busy", 64'(busy), 64'd1);
    chk("ar_run_ghr_clr", 64'(spec_ghr), 64'd0);
    @(negedge clk) rst = 1'b1;
    tick();
    chk("ar_run_restart_init", 64'(bus.upd_init), 64'd1);
    chk("ar_run_restart_pc", 64'(bus.upd_pc), 64'd0);
    chk("ar_run_restart_occ", 64'(occupancy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
